// File: rtl/rv_plic_src_filter.sv
// ---------------------------------------------------------------------------
// rv_plic_src_filter
//
// Conditions raw, asynchronous interrupt sources before they reach the PLIC
// source inputs. Each source is processed in three steps:
//   1. A multi-flop synchronizer brings the source into the clk_i domain.
//   2. An optional polarity inversion lets active-low sources be used.
//   3. A debounce filter changes the output only after the new level has
//      been stable for FilterCycles consecutive cycles.
//
// Source 0 is reserved by the PLIC, so its output is forced low.
//
// Ports:
//   clk_i         - single clock for all logic
//   rst_ni        - asynchronous, active-low reset
//   src_i         - raw interrupt sources, asynchronous to clk_i
//   cfg_invert_i  - per-source polarity; 1 = active-low source
//   cfg_bypass_i  - per-source filter bypass; 1 = one register stage only
//   intr_src_o    - conditioned level interrupts for the PLIC
// ---------------------------------------------------------------------------
module rv_plic_src_filter #(
  parameter int unsigned NumSrc       = 58,
  parameter int unsigned SyncStages   = 2,
  parameter int unsigned FilterCycles = 4,
  parameter int unsigned CntW         = $clog2(FilterCycles + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumSrc-1:0] src_i,
  input  logic [NumSrc-1:0] cfg_invert_i,
  input  logic [NumSrc-1:0] cfg_bypass_i,
  output logic [NumSrc-1:0] intr_src_o
);

  // Terminal count: a mismatch seen on this count value is the
  // FilterCycles-th consecutive one, so the output may change.
  localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);

  logic [NumSrc-1:0] sync_d [SyncStages];
  logic [NumSrc-1:0] sync_q [SyncStages];

  logic [CntW-1:0]   cnt_d  [NumSrc];
  logic [CntW-1:0]   cnt_q  [NumSrc];

  logic [NumSrc-1:0] out_d;
  logic [NumSrc-1:0] out_q;

  logic [NumSrc-1:0] s_eff;

  // Synchronizer chain: stage 0 samples the raw pins, the last stage is the
  // value the rest of the logic trusts.
  always_comb begin
    for (int i = 0; i < SyncStages; i++) begin
      sync_d[i] = '0;
    end
    sync_d[0] = src_i;
    for (int i = 1; i < SyncStages; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // The synchronizer resets to 0 without regard to polarity, so an inverted
  // source idling high still reads as inactive once it has propagated.
  assign s_eff = sync_q[SyncStages-1] ^ cfg_invert_i;

  // Debounce filter. The counter tracks how many consecutive cycles the
  // effective level has disagreed with the output; any agreeing cycle
  // clears it, so short glitches never reach the output.
  always_comb begin
    out_d = out_q;
    for (int s = 0; s < NumSrc; s++) begin
      cnt_d[s] = '0;
      if (cfg_bypass_i[s]) begin
        out_d[s] = s_eff[s];
      end else if (s_eff[s] == out_q[s]) begin
        cnt_d[s] = '0;
      end else if (cnt_q[s] == CntMax) begin
        out_d[s] = s_eff[s];
        cnt_d[s] = '0;
      end else begin
        cnt_d[s] = cnt_q[s] + CntW'(1);
      end
    end
    // Source 0 is unused by the PLIC; keep it permanently inactive.
    out_d[0] = 1'b0;
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SyncStages; i++) begin
        sync_q[i] <= '0;
      end
      for (int s = 0; s < NumSrc; s++) begin
        cnt_q[s] <= '0;
      end
      out_q <= '0;
    end else begin
      for (int i = 0; i < SyncStages; i++) begin
        sync_q[i] <= sync_d[i];
      end
      for (int s = 0; s < NumSrc; s++) begin
        cnt_q[s] <= cnt_d[s];
      end
      out_q <= out_d;
    end
  end

  assign intr_src_o = out_q;

endmodule

// File: tb/tb_rv_plic_src_filter.sv
// ---------------------------------------------------------------------------
// tb_rv_plic_src_filter
//
// Self-checking bench for rv_plic_src_filter. A reference model predicts
// the output from the source history: an input sample becomes visible after
// the synchronizer delay, and the output takes the effective level once the
// most recent FilterCycles samples all disagree with the current output.
// Directed scenarios pin down exact latencies; a random phase follows.
// ---------------------------------------------------------------------------
module tb_rv_plic_src_filter;

  localparam int NumSrc       = 58;
  localparam int SyncStages   = 2;
  localparam int FilterCycles = 4;

  localparam logic [NumSrc-1:0] AllOnes = '1;
  localparam logic [NumSrc-1:0] AllNz   = {{(NumSrc-1){1'b1}}, 1'b0};

  logic              clk;
  logic              rstN;
  logic [NumSrc-1:0] srcV;
  logic [NumSrc-1:0] invV;
  logic [NumSrc-1:0] bypV;
  logic [NumSrc-1:0] dutOut;

  int checks;
  int errors;

  rv_plic_src_filter #(
    .NumSrc       (NumSrc),
    .SyncStages   (SyncStages),
    .FilterCycles (FilterCycles)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .src_i        (srcV),
    .cfg_invert_i (invV),
    .cfg_bypass_i (bypV),
    .intr_src_o   (dutOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: srcPipe delays raw samples by the synchronizer depth,
  // effHist keeps the last FilterCycles effective levels seen by the filter.
  logic [NumSrc-1:0] srcPipe [SyncStages];
  logic [NumSrc-1:0] effHist [FilterCycles];
  logic [NumSrc-1:0] modelOut;
  logic [NumSrc-1:0] effNow;
  logic              stable;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int k = 0; k < SyncStages; k++) srcPipe[k] = '0;
      for (int k = 0; k < FilterCycles; k++) effHist[k] = '0;
      modelOut = '0;
    end else begin
      effNow = srcPipe[SyncStages-1] ^ invV;
      for (int k = FilterCycles - 1; k > 0; k--) effHist[k] = effHist[k-1];
      effHist[0] = effNow;
      for (int s = 1; s < NumSrc; s++) begin
        if (bypV[s]) begin
          modelOut[s] = effNow[s];
        end else begin
          stable = 1'b1;
          for (int k = 0; k < FilterCycles; k++) begin
            if (effHist[k][s] == modelOut[s]) stable = 1'b0;
          end
          if (stable) modelOut[s] = effNow[s];
        end
      end
      for (int k = SyncStages - 1; k > 0; k--) srcPipe[k] = srcPipe[k-1];
      srcPipe[0] = srcV;
    end
  end

  task automatic applyStimulus(input logic [NumSrc-1:0] s,
                               input logic [NumSrc-1:0] inv,
                               input logic [NumSrc-1:0] byp);
    srcV = s;
    invV = inv;
    bypV = byp;
  endtask

  task automatic checkOutput(input string tag,
                             input logic [NumSrc-1:0] observed,
                             input logic [NumSrc-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checkOutput(tag, {{(NumSrc-1){1'b0}}, observed}, {{(NumSrc-1){1'b0}}, expected});
  endtask

  // Advance n cycles; at each falling edge compare against the model.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      checkOutput("model", dutOut, modelOut);
    end
  endtask

  function automatic logic [NumSrc-1:0] randVec();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[NumSrc-1:0];
  endfunction

  bit chatPat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    checks = 0;
    errors = 0;
    rstN   = 1'b0;
    applyStimulus(AllOnes, '0, '0);

    // Reset with all sources active, then exact qualification latency.
    repeat (3) @(negedge clk);
    checkOutput("reset_hold", dutOut, '0);
    rstN = 1'b1;
    step(5);
    checkOutput("latency_early", dutOut, '0);
    step(1);
    checkOutput("latency_exact", dutOut, AllNz);

    // Return everything low.
    applyStimulus('0, '0, '0);
    step(8);
    checkOutput("all_low", dutOut, '0);

    // Glitch of 3 cycles is rejected; 4 cycles passes.
    srcV[5] = 1'b1;
    step(3);
    srcV[5] = 1'b0;
    step(10);
    checkBit("glitch_reject", dutOut[5], 1'b0);
    srcV[5] = 1'b1;
    step(4);
    srcV[5] = 1'b0;
    step(1);
    checkBit("glitch_pass_early", dutOut[5], 1'b0);
    step(1);
    checkBit("glitch_pass", dutOut[5], 1'b1);
    step(3);
    checkBit("glitch_hold", dutOut[5], 1'b1);
    step(1);
    checkBit("glitch_fall", dutOut[5], 1'b0);
    step(4);

    // Chatter: the single low sample restarts qualification.
    for (int i = 0; i < 8; i++) begin
      srcV[9] = chatPat[i];
      step(1);
    end
    step(1);
    checkBit("chatter_early", dutOut[9], 1'b0);
    step(1);
    checkBit("chatter_rise", dutOut[9], 1'b1);
    srcV[9] = 1'b0;
    step(8);

    // Inversion: active-low source idling high stays inactive.
    srcV[12] = 1'b1;
    invV[12] = 1'b1;
    step(10);
    checkBit("invert_idle", dutOut[12], 1'b0);
    srcV[12] = 1'b0;
    step(5);
    checkBit("invert_rise_early", dutOut[12], 1'b0);
    step(1);
    checkBit("invert_rise", dutOut[12], 1'b1);
    invV[12] = 1'b0;
    step(3);
    checkBit("invert_toggle_early", dutOut[12], 1'b1);
    step(1);
    checkBit("invert_toggle", dutOut[12], 1'b0);
    step(4);

    // Bypass: a one-cycle pulse passes through after three edges.
    bypV[20] = 1'b1;
    step(2);
    srcV[20] = 1'b1;
    step(1);
    srcV[20] = 1'b0;
    step(1);
    checkBit("bypass_pre", dutOut[20], 1'b0);
    step(1);
    checkBit("bypass_pulse", dutOut[20], 1'b1);
    step(1);
    checkBit("bypass_pulse_end", dutOut[20], 1'b0);
    bypV[20] = 1'b0;

    // Bypass turned off while a change is in flight: normal latency applies.
    bypV[30] = 1'b1;
    step(2);
    srcV[30] = 1'b1;
    step(1);
    bypV[30] = 1'b0;
    step(2);
    checkBit("bypass_off_no_early", dutOut[30], 1'b0);
    step(2);
    checkBit("bypass_off_edge5", dutOut[30], 1'b0);
    step(1);
    checkBit("bypass_off_rise", dutOut[30], 1'b1);
    srcV[30] = 1'b0;
    step(8);

    // Asynchronous reset in the middle of activity.
    applyStimulus(AllOnes, '0, '0);
    step(8);
    checkOutput("pre_reset_high", dutOut, AllNz);
    srcV[31:1] = '0;
    step(3);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async_reset", dutOut, '0);
    step(1);
    srcV = AllOnes;
    rstN = 1'b1;
    step(5);
    checkOutput("requal_early", dutOut, '0);
    step(1);
    checkOutput("requal", dutOut, AllNz);

    // Random phase: sparse source toggles with occasional config changes.
    applyStimulus('0, '0, '0);
    step(8);
    for (int c = 0; c < 400; c++) begin
      if ((c % 3) == 0) srcV = srcV ^ (randVec() & randVec() & randVec());
      if ((c % 25) == 0) begin
        invV = invV ^ (randVec() & randVec() & randVec());
        bypV = bypV ^ (randVec() & randVec() & randVec());
      end
      if ((c % 11) == 0) srcV = srcV ^ (randVec() & randVec() & randVec() & randVec());
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
